// File: rtl/fifo_wr_arbiter_ctrl_if.sv
// fifo_wr_arbiter_ctrl_if: writer/reader handshake, memory port and status bundle of the FIFO controller.
interface fifo_wr_arbiter_ctrl_if #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_LEN  = 6
);
    logic [1:0]           wr_valid;
    logic [1:0]           wr_ready;
    logic [DATA_SIZE-1:0] wr_data0;
    logic [DATA_SIZE-1:0] wr_data1;
    logic                 rd_req;
    logic                 rd_ack;
    logic                 clr_err;
    logic                 w_en;
    logic [ADDR_LEN-2:0]  w_addr;
    logic [DATA_SIZE-1:0] w_data;
    logic                 r_en;
    logic [ADDR_LEN-2:0]  r_addr;
    logic [ADDR_LEN-1:0]  count;
    logic                 full;
    logic                 empty;
    logic                 almost_full;
    logic                 overflow_err;
    logic                 underflow_err;

    modport master (
        output wr_valid, wr_data0, wr_data1, rd_req, clr_err,
        input  wr_ready, rd_ack, w_en, w_addr, w_data, r_en, r_addr,
               count, full, empty, almost_full, overflow_err, underflow_err
    );

    modport slave (
        input  wr_valid, wr_data0, wr_data1, rd_req, clr_err,
        output wr_ready, rd_ack, w_en, w_addr, w_data, r_en, r_addr,
               count, full, empty, almost_full, overflow_err, underflow_err
    );
endinterface

// File: rtl/fifo_wr_arbiter_ctrl.sv
// fifo_wr_arbiter_ctrl: round-robin two-writer arbiter and pointer/status controller for a single-clock FIFO memory.
module fifo_wr_arbiter_ctrl #(
    parameter int DATA_SIZE = 32,
    parameter int MEM_SIZE  = 32,
    parameter int ADDR_LEN  = 6,
    parameter int AFULL_GAP = 4
) (
    input logic clk,
    input logic resetn,
    fifo_wr_arbiter_ctrl_if.slave bus
);
    logic [ADDR_LEN-1:0] wptr, rptr, count;
    logic                last_gnt, ovf, unf, full, empty, win, rd;
    logic [1:0]          gnt;

    assign empty = wptr == rptr;
    assign full  = (wptr[ADDR_LEN-1] != rptr[ADDR_LEN-1]) && (wptr[ADDR_LEN-2:0] == rptr[ADDR_LEN-2:0]);
    assign count = wptr - rptr;

    always_comb begin
        win = &bus.wr_valid ? ~last_gnt : bus.wr_valid[1];
        gnt = (full || bus.wr_valid == 2'b00) ? 2'b00 : (win ? 2'b10 : 2'b01);
    end

    assign rd                = bus.rd_req & ~empty;
    assign bus.wr_ready      = gnt;
    assign bus.w_en          = |gnt;
    assign bus.w_addr        = wptr[ADDR_LEN-2:0];
    assign bus.w_data        = DATA_SIZE'(gnt[1] ? bus.wr_data1 : bus.wr_data0);
    assign bus.rd_ack        = rd;
    assign bus.r_en          = rd;
    assign bus.r_addr        = rptr[ADDR_LEN-2:0];
    assign bus.count         = count;
    assign bus.full          = full;
    assign bus.empty         = empty;
    assign bus.almost_full   = (ADDR_LEN'(MEM_SIZE) - count) <= ADDR_LEN'(AFULL_GAP);
    assign bus.overflow_err  = ovf;
    assign bus.underflow_err = unf;

    // error set condition outranks a same-cycle clear
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr     <= '0;
            rptr     <= '0;
            last_gnt <= 1'b1;
            ovf      <= 1'b0;
            unf      <= 1'b0;
        end else begin
            wptr <= wptr + ADDR_LEN'(bus.w_en);
            rptr <= rptr + ADDR_LEN'(rd);
            if (bus.w_en) last_gnt <= gnt[1];
            ovf <= ((|bus.wr_valid) & full) | (ovf & ~bus.clr_err);
            unf <= (bus.rd_req & empty) | (unf & ~bus.clr_err);
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter_ctrl.sv
// tb_fifo_wr_arbiter_ctrl: randomized scoreboard bench with a queue-based FIFO model and a behavioural memory.
module tb_fifo_wr_arbiter_ctrl;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    fifo_wr_arbiter_ctrl_if #(.DATA_SIZE(32), .ADDR_LEN(6)) bus ();

    fifo_wr_arbiter_ctrl #(.DATA_SIZE(32), .MEM_SIZE(32), .ADDR_LEN(6), .AFULL_GAP(4)) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] mq[$];
    logic [31:0] exp_q[$];
    logic        mlast = 1'b1;
    logic        movf = 1'b0, munf = 1'b0;
    logic [4:0]  wa = '0, ra = '0;

    logic [31:0] mem [32];
    logic [31:0] r_data;
    logic        r_valid;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= bus.r_en;
            if (bus.r_en) r_data <= mem[bus.r_addr];
            if (bus.w_en) mem[bus.w_addr] <= bus.w_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (r_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL r_data: got %0h expected nothing (no pop outstanding)", r_data);
            end else begin
                chk("r_data", r_data, exp_q.pop_front());
            end
        end
    end

    task automatic check_status();
        int n = mq.size();
        chk("count", 32'(bus.count), n);
        chk("full", 32'(bus.full), 32'(n == 32));
        chk("empty", 32'(bus.empty), 32'(n == 0));
        chk("almost_full", 32'(bus.almost_full), 32'((32 - n) <= 4));
        chk("overflow_err", 32'(bus.overflow_err), 32'(movf));
        chk("underflow_err", 32'(bus.underflow_err), 32'(munf));
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        bus.wr_valid = 2'b00;
        bus.wr_data0 = '0;
        bus.wr_data1 = '0;
        bus.rd_req = 1'b0;
        bus.clr_err = 1'b0;
        #1;
        mq.delete();
        exp_q.delete();
        mlast = 1'b1;
        movf = 1'b0;
        munf = 1'b0;
        wa = '0;
        ra = '0;
        check_status();
        chk("rst_wr_ready", 32'(bus.wr_ready), 0);
        chk("rst_rd_ack", 32'(bus.rd_ack), 0);
        chk("rst_w_en", 32'(bus.w_en), 0);
        chk("rst_r_en", 32'(bus.r_en), 0);
        chk("rst_w_addr", 32'(bus.w_addr), 0);
        chk("rst_r_addr", 32'(bus.r_addr), 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic cycle(input logic [1:0] v, input logic rq, input logic clr);
        logic [31:0] d0, d1, ed;
        logic [1:0]  eg;
        logic        er;
        int          n;
        d0 = $urandom;
        d1 = $urandom;
        bus.wr_valid = v;
        bus.wr_data0 = d0;
        bus.wr_data1 = d1;
        bus.rd_req = rq;
        bus.clr_err = clr;
        #1;
        n = mq.size();
        check_status();
        eg = (n == 32 || v == 2'b00) ? 2'b00 : (v == 2'b11 ? (mlast ? 2'b01 : 2'b10) : v);
        ed = eg[1] ? d1 : d0;
        er = rq && n != 0;
        chk("wr_ready", 32'(bus.wr_ready), 32'(eg));
        chk("w_en", 32'(bus.w_en), 32'(eg != 2'b00));
        if (eg != 2'b00) begin
            chk("w_addr", 32'(bus.w_addr), 32'(wa));
            chk("w_data", bus.w_data, ed);
        end
        chk("rd_ack", 32'(bus.rd_ack), 32'(er));
        chk("r_en", 32'(bus.r_en), 32'(er));
        if (er) chk("r_addr", 32'(bus.r_addr), 32'(ra));
        if (er) begin
            exp_q.push_back(mq.pop_front());
            ra = ra + 5'd1;
        end
        if (eg != 2'b00) begin
            mq.push_back(ed);
            wa = wa + 5'd1;
            mlast = eg[1];
        end
        movf = (v != 2'b00 && n == 32) | (movf & ~clr);
        munf = (rq && n == 0) | (munf & ~clr);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && mq.size() != 0; i++) cycle(2'b00, 1'b1, 1'b0);
    endtask

    initial begin
        int pushed;
        logic [1:0] v;
        logic rq;
        do_reset();
        cycle(2'b11, 1'b0, 1'b0);

        do_reset();
        for (int i = 0; i < 32; i++) cycle(2'b01, 1'b0, 1'b0);
        cycle(2'b01, 1'b0, 1'b0);
        cycle(2'b00, 1'b0, 1'b0);
        cycle(2'b00, 1'b0, 1'b1);
        cycle(2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cycle(2'b01, 1'b0, 1'b0);
        cycle(2'b11, 1'b1, 1'b0);
        cycle(2'b00, 1'b0, 1'b1);
        drain();

        do_reset();
        for (int i = 0; i < 6; i++) cycle(2'b11, 1'b0, 1'b0);
        cycle(2'b00, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) cycle(2'($urandom_range(1, 3)), 1'b1, 1'b0);
        drain();
        cycle(2'b00, 1'b1, 1'b0);
        cycle(2'b00, 1'b1, 1'b1);
        cycle(2'b00, 1'b0, 1'b1);

        pushed = 0;
        for (int i = 0; i < 2000 && (pushed < 80 || mq.size() != 0); i++) begin
            v = (pushed < 80 && mq.size() < 32 && $urandom_range(0, 2) != 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            rq = mq.size() != 0 && $urandom_range(0, 2) != 0;
            if (v != 2'b00) pushed++;
            cycle(v, rq, 1'b0);
        end
        chk("stream_pushed", pushed, 80);
        chk("stream_ovf", 32'(bus.overflow_err), 0);
        chk("stream_unf", 32'(bus.underflow_err), 0);

        cycle(2'b00, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) cycle(2'b10, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 3; i++) cycle(2'b00, 1'b0, 1'b0);
        chk("exp_q_left", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter_ctrl.md
# fifo_wr_arbiter_ctrl

Single-clock controller that shares the write port of the team's FIFO memory between two writers and sequences its read port. It owns the write/read pointers, drives the memory's write/read enables and addresses, and publishes occupancy, full/empty and sticky error flags. It sits directly in front of a `fifo_memory` instance whose `wclk` and `rclk` are both tied to `clk`.

## Interface
- `DATA_SIZE`, 32, width of a FIFO word.
- `MEM_SIZE`, 32, FIFO depth; equals 2^(ADDR_LEN-1).
- `ADDR_LEN`, 6, pointer width including the wrap bit; memory address is ADDR_LEN-1 bits.
- `AFULL_GAP`, 4, `almost_full` asserts when free slots are ≤ AFULL_GAP.

- `clk`  in  1  single clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `wr_valid`  in  2  write request from writer 0 (bit 0) and writer 1 (bit 1).
- `wr_data0`, `wr_data1`  in  DATA_SIZE  write data per writer.
- `wr_ready`  out  2  one-hot or zero; bit i high means writer i's word is accepted this cycle.
- `rd_req`  in  1  pop request.
- `rd_ack`  out  1  pop accepted this cycle.
- `clr_err`  in  1  synchronous clear of both error flags.
- `w_en`  out  1  memory write enable.
- `w_addr`  out  ADDR_LEN-1  memory write address.
- `w_data`  out  DATA_SIZE  memory write data.
- `r_en`  out  1  memory read enable.
- `r_addr`  out  ADDR_LEN-1  memory read address.
- `count`  out  ADDR_LEN  occupancy, 0..MEM_SIZE.
- `full`, `empty`, `almost_full`  out  1  status.
- `overflow_err`, `underflow_err`  out  1  sticky errors.

## Operation
- State: `wptr`, `rptr` (ADDR_LEN bits each), `last_gnt` (1 bit), and two error flags.
- `empty` = (wptr == rptr). `full` = MSBs differ and the lower ADDR_LEN-1 bits are equal. `count` = wptr − rptr, modulo 2^ADDR_LEN. `almost_full` = (MEM_SIZE − count) ≤ AFULL_GAP.
- Arbitration is combinational from `wr_valid`, `last_gnt` and `full`:
  - If `full`: no grant.
  - One requester valid: that requester wins.
  - Both valid: winner = ~`last_gnt`, i.e. round-robin.
  - `last_gnt` updates to the winner on every accepted write.
- `w_en` = |wr_ready. `w_addr` = wptr[ADDR_LEN-2:0]. `w_data` = winner's data, or `wr_data0` when idle.
- `wptr` increments on `w_en`.
- `rd_ack` = `r_en` = rd_req & ~empty. `r_addr` = rptr[ADDR_LEN-2:0]. `rptr` increments on `r_en`.
- Pointers wrap naturally at 2^ADDR_LEN; the address wraps from MEM_SIZE−1 to 0.
- Simultaneous push and pop:
  - Both are allowed when neither full nor empty; `count` is unchanged.
  - When full: the pop is accepted and the push is refused (status is from registered pointers).
  - When empty: the push is accepted and the pop is refused.
- `overflow_err` sets on any cycle with |wr_valid & full.
- `underflow_err` sets on any cycle with rd_req & empty.
- `clr_err` clears both errors. A set condition in the same cycle as `clr_err` wins.

## Timing
- Reset values:
  - Pointers 0, `last_gnt` = 1 (writer 0 has first priority), errors 0.
  - Outputs: `count` 0, `empty` 1, `full` 0, `almost_full` 0, `wr_ready` 0, `rd_ack` 0, `w_en` 0, `r_en` 0, `w_addr` 0, `r_addr` 0.
- Handshake outputs (`wr_ready`, `rd_ack`, `w_en`, `r_en`, addresses, `w_data`) are combinational, valid in the same cycle as the request.
- Status outputs derive only from registers and change the cycle after the accepting edge.
- Write accepted at edge N: the memory stores at edge N, and `empty` deasserts after edge N.
- Earliest pop of that word is at edge N+1; memory `r_data`/`r_valid` follow after edge N+1. Minimum write-to-data latency is 2 edges.
- Reset asserted mid-operation: state clears immediately (asynchronously), and all in-flight requests are dropped. Memory contents are don't-care and are never read before being rewritten.

## Test plan
- Reset, then idle: `empty`=1, `count`=0, `full`=0, no enables. Deassert `resetn`; both writers valid on the first cycle → `wr_ready`=01.
- Writer 0 alone, 32 consecutive writes → `w_addr` 0..31, `full`=1 and `almost_full`=1 after the 32nd. 33rd request → `wr_ready`=00 and `overflow_err`=1, which holds until `clr_err`.
- Both writers valid continuously for 6 cycles → grants 0,1,0,1,0,1. Data written equals the winner's word; `count`=6.
- At `count`=5, push and pop in the same cycle for 10 cycles → `count` stays 5 and both pointers advance by 10. With `full` and both requests: only pop accepted, `count` 31.
- Wrap-around: stream 80 words in and out with random gaps → addresses wrap 31→0, the popped sequence through `fifo_memory` matches the push order, and no error flags are raised.
- `rd_req` while empty → `rd_ack`=0, `r_en`=0, `underflow_err`=1. Assert `resetn` low at `count`=12 → `count`=0, `empty`=1 and errors 0 immediately.
